// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and its byte serialiser.
package inst_mem_loader_pkg;

   localparam int unsigned ADDR_W_DEF     = 12;
   localparam int unsigned MAX_WORDS_DEF  = 1024;
   localparam int unsigned CNT_W_DEF      = 11;
   localparam int unsigned BYTES_PER_WORD = 4;

   // Byte-lane ordering shared with the instruction memory: lane 0 holds
   // the least-significant byte and sits at the lowest byte address.
   localparam bit LANE_LITTLE_ENDIAN = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_ACCEPT,
      ST_WRITE,
      ST_DONE
   } state_e;

   // Byte of a word that belongs at byte offset idx within the word.
   function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] idx);
      logic [1:0] lane;
      lane = LANE_LITTLE_ENDIAN ? idx : ~idx;
      return word[{lane, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/inst_mem_loader_word_byte_serializer.sv
// Holds one instruction word and steps through its four bytes, presenting the
// current byte and its lane offset from registers.
module word_byte_serializer
   import inst_mem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic        advance_i,
   input  logic [31:0] word_i,
   output logic [7:0]  byte_o,
   output logic [1:0]  lane_o,
   output logic        last_o
);

   logic [31:0] word_q;
   logic [1:0]  idx_q;
   logic [7:0]  byte_q;

   // Capture a new word at lane 0, or move on to the next lane.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q <= '0;
         idx_q  <= '0;
         byte_q <= '0;
      end else if (load_i) begin
         word_q <= word_i;
         idx_q  <= '0;
         byte_q <= lane_byte(word_i, 2'd0);
      end else if (advance_i) begin
         idx_q  <= idx_q + 2'd1;
         byte_q <= lane_byte(word_q, idx_q + 2'd1);
      end
   end

   assign byte_o = byte_q;
   assign lane_o = idx_q;
   assign last_o = (idx_q == 2'd3);

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: accepts 32-bit words over valid/ready and writes
// each as four little-endian byte writes at consecutive addresses.
module inst_mem_loader
   import inst_mem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned MAX_WORDS = MAX_WORDS_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              in_valid,
   input  logic [31:0]       in_word,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  words_written
);

   localparam int unsigned      EXT_W       = ADDR_W + 3;
   localparam logic [EXT_W-1:0] MEM_BYTES   = EXT_W'(1) << ADDR_W;
   localparam logic [CNT_W-1:0] MAX_WORDS_C = CNT_W'(MAX_WORDS);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [CNT_W-1:0]    ww_q, ww_d;
   logic                err_q, err_d;
   logic                in_ready_q, mem_we_q, busy_q, done_q;

   logic                ser_load, ser_advance, ser_last;
   logic [1:0]          ser_lane;
   logic [7:0]          ser_byte;
   logic [EXT_W-1:0]    job_end;
   logic                range_err;

   word_byte_serializer u_ser (
      .clk       (clk),
      .reset     (reset),
      .load_i    (ser_load),
      .advance_i (ser_advance),
      .word_i    (in_word),
      .byte_o    (ser_byte),
      .lane_o    (ser_lane),
      .last_o    (ser_last)
   );

   // Job range check, evaluated wide enough that the end address cannot wrap.
   always_comb begin
      job_end   = EXT_W'(cur_addr_q) + (EXT_W'(count_q) << 2);
      range_err = (job_end > MEM_BYTES) || (count_q > MAX_WORDS_C);
   end

   // Next-state logic for the job FSM, address counter and word counter.
   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      count_d     = count_q;
      ww_d        = ww_q;
      err_d       = err_q;
      ser_load    = 1'b0;
      ser_advance = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cur_addr_d = base_addr;
               count_d    = word_count;
               ww_d       = '0;
               err_d      = 1'b0;
               state_d    = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if ((cur_addr_q[1:0] != 2'b00) || range_err) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (count_q == '0) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_ACCEPT;
            end
         end
         ST_ACCEPT: begin
            // in_ready is high exactly while in ACCEPT.
            if (in_valid) begin
               ser_load = 1'b1;
               state_d  = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (ser_last) begin
               cur_addr_d = cur_addr_q + ADDR_W'(BYTES_PER_WORD);
               ww_d       = ww_q + CNT_W'(1);
               state_d    = (ww_d == count_q) ? ST_DONE : ST_ACCEPT;
            end else begin
               ser_advance = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, job registers and outputs; outputs are registered from next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cur_addr_q <= '0;
         count_q    <= '0;
         ww_q       <= '0;
         err_q      <= 1'b0;
         in_ready_q <= 1'b0;
         mem_we_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         count_q    <= count_d;
         ww_q       <= ww_d;
         err_q      <= err_d;
         in_ready_q <= (state_d == ST_ACCEPT);
         mem_we_q   <= (state_d == ST_WRITE);
         busy_q     <= (state_d != ST_IDLE);
         done_q     <= (state_d == ST_DONE);
      end
   end

   assign in_ready      = in_ready_q;
   assign mem_we        = mem_we_q;
   // cur_addr is word-aligned whenever writes happen, so concatenating the
   // lane offset equals cur_addr + idx without an adder on the output path.
   assign mem_addr      = {cur_addr_q[ADDR_W-1:2], ser_lane};
   assign mem_wdata     = ser_byte;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign words_written = ww_q;

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Write-side companion to the byte-addressed, little-endian 32-bit instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream and serialises each word into four byte writes at consecutive addresses, least-significant byte at the lowest address.
- Used by the testbench and boot path to program instruction memory before the fetch stage runs, replacing hard-coded initial contents.

Parameters:
ADDR_W, 12, byte address width; memory holds 2^ADDR_W bytes
MAX_WORDS, 1024, maximum words per load job (2^ADDR_W / 4)
CNT_W, 11, width of word counters (holds 0..MAX_WORDS)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin load job; sampled only in IDLE
base_addr  input  ADDR_W  first byte address of the job; must be word-aligned
word_count  input  CNT_W  number of words in the job, 0..MAX_WORDS
in_valid  input  1  in_word is valid
in_word  input  32  instruction word to store
in_ready  output  1  loader accepts in_word this cycle
mem_we  output  1  byte write enable to instruction memory
mem_addr  output  ADDR_W  byte write address
mem_wdata  output  8  byte write data
busy  output  1  job in progress (any state except IDLE)
done  output  1  one-cycle pulse at job end, success or error
err  output  1  job rejected; sticky until next accepted start
words_written  output  CNT_W  words fully written in current/last job

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: all outputs registered. All outputs reset to 0. State resets to IDLE.
- Reset mid-job: the partial word is abandoned; already-written bytes stay in memory; no done pulse is generated.
- States: IDLE, CHECK, ACCEPT, WRITE, DONE.
- IDLE: in_ready=0, busy=0. On start=1, latch base_addr and word_count, clear err and words_written, go to CHECK. A start asserted while busy is ignored.
- CHECK (1 cycle), in priority order:
  - base_addr[1:0]!=0 -> err=1, go to DONE.
  - base_addr + 4*word_count > 2^ADDR_W (computed ADDR_W+3 bits wide, no wrap) -> err=1, go to DONE.
  - word_count==0 -> go to DONE.
  - Otherwise -> go to ACCEPT.
  - On any error no memory write occurs.
- ACCEPT: in_ready=1. On in_valid && in_ready, latch in_word, set byte index to 0, go to WRITE. in_word is ignored while in_ready=0.
- WRITE (exactly 4 cycles): mem_we=1, mem_addr=cur_addr+idx, mem_wdata=word[8*idx+7:8*idx], for idx 0,1,2,3.
- After idx 3: cur_addr += 4 and words_written += 1 in the same cycle. If words_written equals word_count, go to DONE; otherwise return to ACCEPT.
- DONE: done=1 for exactly one cycle, then IDLE. err holds its value.
- Timing:
  - Handshake in cycle N -> byte writes visible in cycles N+1..N+4.
  - Next in_ready is asserted at N+5.
  - Peak throughput is 1 word per 5 cycles.
  - in_ready is never high while mem_we is high.
- Boundary: the last legal job ends exactly at byte 2^ADDR_W-1. mem_addr never wraps.

Decomposition:
- Shared package holds:
  - state enum (IDLE, CHECK, ACCEPT, WRITE, DONE);
  - BYTES_PER_WORD=4;
  - ADDR_W, MAX_WORDS, CNT_W defaults;
  - the little-endian byte-lane ordering constant, shared with the instruction memory.
- One natural sub-module: word_byte_serializer. It holds the word register and 2-bit byte index, and produces mem_wdata and the lane offset. The top level owns the FSM, address counter and range checks.

Test Plan:
- base=0, count=5, words 3,6,16,32,64 with in_valid held high -> bytes 0..19 = 03 00 00 00 06 00 00 00 10 00 00 00 20 00 00 00 40 00 00 00; a fetch at readAddr 4 returns 6; done pulses once; words_written=5; err=0.
- base=0x100, count=2, word 0xDEADBEEF with in_valid toggled 1/0 per cycle -> bytes 0x100..0x103 = EF BE AD DE; no write while the loader waits in ACCEPT; in_ready never high with mem_we high.
- base=0x102, count=1 -> err=1, zero mem_we cycles, done pulse 2 cycles after start.
- Range cases:
  - base=0xFFC, count=1 -> writes 0xFFC..0xFFF, err=0.
  - base=0xFFC, count=2 -> err=1, no writes.
  - count=0 -> done pulse, err=0, no writes.
- Assert reset after the 2nd byte of word 3 in a 5-word job -> all outputs 0 immediately; state IDLE; no done pulse. A fresh start then completes normally.
- start pulsed while busy, mid-job -> ignored; the job finishes with the original base and count.
